// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin ownership per bus cycle,
// with a watchdog that aborts a slave that never answers a strobe.
module wb_arbiter #(
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_SEL_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic [WB_ADDR_WIDTH-1:0] wb_m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_m0_data_i,
  input  logic                     wb_m0_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_m0_sel_i,
  input  logic                     wb_m0_stb_i,
  input  logic                     wb_m0_cyc_i,
  output logic                     wb_m0_ack_o,
  output logic                     wb_m0_err_o,
  output logic [WB_DATA_WIDTH-1:0] wb_m0_data_o,

  input  logic [WB_ADDR_WIDTH-1:0] wb_m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_m1_data_i,
  input  logic                     wb_m1_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_m1_sel_i,
  input  logic                     wb_m1_stb_i,
  input  logic                     wb_m1_cyc_i,
  output logic                     wb_m1_ack_o,
  output logic                     wb_m1_err_o,
  output logic [WB_DATA_WIDTH-1:0] wb_m1_data_o,

  output logic [WB_ADDR_WIDTH-1:0] wb_s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_s_data_o,
  output logic                     wb_s_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_s_sel_o,
  output logic                     wb_s_stb_o,
  output logic                     wb_s_cyc_o,
  input  logic                     wb_s_ack_i,
  input  logic                     wb_s_err_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_s_data_i,

  output logic [1:0]               grant_o,
  output logic                     timeout_o
);

  localparam logic [15:0] CntMax  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAbort
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic                     own_cyc;
  logic                     own_stb;
  logic                     own_we;
  logic [WB_ADDR_WIDTH-1:0] own_addr;
  logic [WB_DATA_WIDTH-1:0] own_data;
  logic [WB_SEL_WIDTH-1:0]  own_sel;
  logic                     busy;

  // owner_q is one-hot; the slave side only ever sees the registered owner
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_sel  = '0;
    if (owner_q[0]) begin
      own_cyc  = wb_m0_cyc_i;
      own_stb  = wb_m0_stb_i;
      own_we   = wb_m0_we_i;
      own_addr = wb_m0_addr_i;
      own_data = wb_m0_data_i;
      own_sel  = wb_m0_sel_i;
    end else if (owner_q[1]) begin
      own_cyc  = wb_m1_cyc_i;
      own_stb  = wb_m1_stb_i;
      own_we   = wb_m1_we_i;
      own_addr = wb_m1_addr_i;
      own_data = wb_m1_data_i;
      own_sel  = wb_m1_sel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      owner_q   <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // last_q == 1 means m1 owned the bus last, so m0 wins a tie
        if (wb_m0_cyc_i && wb_m1_cyc_i) begin
          owner_d = last_q ? 2'b01 : 2'b10;
          state_d = StBusy;
        end else if (wb_m0_cyc_i) begin
          owner_d = 2'b01;
          state_d = StBusy;
        end else if (wb_m1_cyc_i) begin
          owner_d = 2'b10;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!own_cyc) begin
          state_d = StIdle;
          owner_d = 2'b00;
          last_d  = owner_q[1];
        end else if (own_stb && !wb_s_ack_i && !wb_s_err_i) begin
          if (cnt_q == CntLast) begin
            state_d   = StAbort;
            timeout_d = 1'b1;
          end else begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 16'd1;
          end
        end
      end
      StAbort: begin
        if (!own_cyc) begin
          state_d = StIdle;
          owner_d = 2'b00;
          last_d  = owner_q[1];
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = 2'b00;
      end
    endcase
  end

  assign busy = (state_q == StBusy);

  assign wb_s_cyc_o  = busy & own_cyc;
  assign wb_s_stb_o  = busy & own_stb;
  assign wb_s_we_o   = busy & own_we;
  assign wb_s_addr_o = own_addr;
  assign wb_s_data_o = own_data;
  assign wb_s_sel_o  = own_sel;

  // Slave responses are dropped outside BUSY, so late acks after an abort vanish
  assign wb_m0_ack_o  = busy & owner_q[0] & wb_s_ack_i;
  assign wb_m1_ack_o  = busy & owner_q[1] & wb_s_ack_i;
  assign wb_m0_err_o  = owner_q[0] & ((busy & wb_s_err_i) | timeout_q);
  assign wb_m1_err_o  = owner_q[1] & ((busy & wb_s_err_i) | timeout_q);
  assign wb_m0_data_o = (busy && owner_q[0]) ? wb_s_data_i : '0;
  assign wb_m1_data_o = (busy && owner_q[1]) ? wb_s_data_i : '0;

  assign grant_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter with round-robin grant and a bus-timeout watchdog.
- Sits between the masters (CPU and a second master such as a debug/loader port) and the slave-side address mux.
- The granted master owns the slave port for its whole cycle (cyc high).
- A slave that never acks is aborted with an error back to the owning master.

Parameters:
WB_DATA_WIDTH, 32, data bus width
WB_ADDR_WIDTH, 32, address bus width
WB_SEL_WIDTH, 4, byte-select width
TIMEOUT_CYCLES, 255, stb-high cycles without ack/err before abort; legal range 2..65535

Ports (mN = m0 and m1, one identical port each):
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous, active-low reset
wb_mN_addr_i  input  WB_ADDR_WIDTH  master address
wb_mN_data_i  input  WB_DATA_WIDTH  master write data
wb_mN_we_i  input  1  master write enable
wb_mN_sel_i  input  WB_SEL_WIDTH  master byte selects
wb_mN_stb_i  input  1  master strobe
wb_mN_cyc_i  input  1  master cycle request
wb_mN_ack_o  output  1  ack routed to master
wb_mN_err_o  output  1  error routed to master (slave err or timeout)
wb_mN_data_o  output  WB_DATA_WIDTH  read data to master
wb_s_addr_o, wb_s_data_o, wb_s_we_o, wb_s_sel_o, wb_s_stb_o, wb_s_cyc_o  output  (as master)  slave-side request
wb_s_ack_i  input  1  slave ack
wb_s_err_i  input  1  slave error
wb_s_data_i  input  WB_DATA_WIDTH  slave read data
grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 0 when idle
timeout_o  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, owner none, last_owner = m1 (so m0 wins the first tie), counter 0.
  - All outputs 0: grant_o, timeout_o, every ack/err, wb_s_cyc_o, wb_s_stb_o, wb_s_we_o.
  - Address, data and sel outputs are also 0.
- States: IDLE, BUSY, ABORT. Owner is a register; slave outputs are a combinational mux of the registered owner only.
- IDLE:
  - Only one master has cyc high: it becomes owner.
  - Both have cyc high: the master other than last_owner wins.
  - Owner is registered and the state moves to BUSY next cycle, so arbitration latency is 1 cycle.
  - Slave cyc/stb stay 0 during IDLE.
- BUSY:
  - wb_s_* follow the owner's signals.
  - Slave ack/err/data go to the owner only. The non-owner sees ack = 0, err = 0, data = 0, including in IDLE and ABORT.
  - Owner drops cyc: the state goes to IDLE next cycle, last_owner is set to owner, and grant_o clears.
  - The other master's request is evaluated in IDLE, giving 1 dead cycle between owners.
  - The non-owner's cyc never preempts a cycle; block transfers (multiple stb with cyc held) stay with the owner.
- Watchdog:
  - The counter increments each BUSY cycle with owner stb high and no slave ack/err.
  - It clears to 0 on ack, err, stb low, or leaving BUSY, and saturates at TIMEOUT_CYCLES.
  - When the counter equals TIMEOUT_CYCLES - 1 and the cycle still has no ack/err: the next cycle enters ABORT.
  - On that entry, owner err_o = 1 for exactly one cycle and timeout_o pulses for one cycle.
- ABORT:
  - wb_s_cyc_o = wb_s_stb_o = 0.
  - Late slave ack/err are ignored and not forwarded.
  - The state stays in ABORT until the owner drops cyc, then goes to IDLE with last_owner = owner.
- Simultaneous events:
  - Slave ack on the same cycle the counter hits its limit: ack wins and no abort occurs.
  - Slave ack and err together: both are forwarded as-is (the slave is non-compliant; no arbitration needed).
- Reset mid-transfer: everything returns to reset values immediately. No ack/err is generated for the interrupted cycle.

Test Plan:
- Single master: m0 write of 0xDEADBEEF to 0x100 with the slave acking 1 cycle after stb → grant_o = 01 one cycle after cyc; wb_s_* mirror m0; m0_ack pulses; m1 sees ack = 0.
- Tie from reset: m0 and m1 raise cyc in the same cycle → m0 granted first. After m0 drops cyc, one IDLE cycle follows, then grant_o = 10. A second tie is granted to m0 again, as round-robin alternates.
- No preemption: m0 holds cyc across 4 back-to-back stb/ack reads (0x11, 0x22, 0x33, 0x44) while m1 requests → m1 is granted only after m0 drops cyc; m0 read data is exact and m1_data_o stays 0.
- Timeout with TIMEOUT_CYCLES = 8: the slave never acks → after 8 stb cycles, m0_err_o and timeout_o pulse once and wb_s_cyc_o falls. A later slave ack is not forwarded. The state returns to IDLE when m0 drops cyc.
- Boundary: with TIMEOUT_CYCLES = 8, the slave acks on exactly the 8th stb cycle → a normal ack is forwarded, with no err and no timeout.
- Reset asserted during a BUSY m1 read → grant_o, wb_s_cyc_o and m1_ack_o are 0 asynchronously. After release, an m1 request is granted normally.
